// File: rtl/fetch_pkg.sv
// Shared constants for the fetch/sequencing stage: widths, opcodes, field slices,
// FSM state encoding and program-counter update selects.
package fetch_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 5;
  localparam int OPCODE_WIDTH  = 3;

  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = '0;

  localparam int OPC_MSB  = DATA_WIDTH - 1;
  localparam int OPC_LSB  = DATA_WIDTH - OPCODE_WIDTH;
  localparam int OPND_MSB = ADDRESS_WIDTH - 1;
  localparam int OPND_LSB = 0;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    S_ADDR,
    S_LATCH,
    S_DECODE,
    S_DISPATCH,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC1,
    PC_INC2,
    PC_LOAD
  } pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: synchronous reset, hold / +1 / +2 / load update; the
// fixed register width gives modulo-2^ADDRESS_WIDTH wrap for free.
module program_counter
  import fetch_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VALUE = RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  pc_sel_t                  sel,
  input  logic [ADDRESS_WIDTH-1:0] load_value,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  logic [ADDRESS_WIDTH-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    case (sel)
      PC_INC1: pc_nxt = pc + ADDRESS_WIDTH'(1);
      PC_INC2: pc_nxt = pc + ADDRESS_WIDTH'(2);
      PC_LOAD: pc_nxt = load_value;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_VALUE;
    else     pc <= pc_nxt;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing stage: fetches from instruction memory, resolves HLT/SKZ/JMP
// locally and hands everything else to execute over a valid/ready handshake.
//
// state      | meaning
// S_ADDR     | pc presented on im_address; memory samples it this cycle
// S_LATCH    | instruction returned; captured into ir
// S_DECODE   | resolve HLT/SKZ/JMP or load the dispatch payload
// S_DISPATCH | ex_valid held until ex_ready; accept advances pc by 1
// S_HALT     | terminal until rst
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] im_address,
  output logic                     im_halt,
  input  logic [DATA_WIDTH-1:0]    im_instruction,
  input  logic                     zero_i,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OPCODE_WIDTH-1:0]  ex_opcode,
  output logic [ADDRESS_WIDTH-1:0] ex_operand,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     halted
);

  state_t                   state, state_nxt;
  logic [DATA_WIDTH-1:0]    ir;
  logic [OPCODE_WIDTH-1:0]  ir_opcode;
  logic [ADDRESS_WIDTH-1:0] ir_operand;
  pc_sel_t                  pc_sel;
  logic                     ir_load;
  logic                     dispatch_set;
  logic                     dispatch_clr;
  logic                     halt_set;

  assign ir_opcode  = ir[OPC_MSB:OPC_LSB];
  assign ir_operand = ir[OPND_MSB:OPND_LSB];
  assign im_address = pc;

  program_counter #(
    .RESET_VALUE(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .sel       (pc_sel),
    .load_value(ir_operand),
    .pc        (pc)
  );

  always_comb begin
    state_nxt    = state;
    pc_sel       = PC_HOLD;
    ir_load      = 1'b0;
    dispatch_set = 1'b0;
    dispatch_clr = 1'b0;
    halt_set     = 1'b0;
    case (state)
      S_ADDR:  state_nxt = S_LATCH;
      S_LATCH: begin
        ir_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (ir_opcode)
          OP_HLT: begin
            halt_set  = 1'b1;
            state_nxt = S_HALT;
          end
          OP_SKZ: begin
            pc_sel    = zero_i ? PC_INC2 : PC_INC1;
            state_nxt = S_ADDR;
          end
          OP_JMP: begin
            pc_sel    = PC_LOAD;
            state_nxt = S_ADDR;
          end
          default: begin
            dispatch_set = 1'b1;
            state_nxt    = S_DISPATCH;
          end
        endcase
      end
      S_DISPATCH: begin
        // ex_ready only steers pc/state; ex_valid itself stays registered
        if (ex_valid && ex_ready) begin
          dispatch_clr = 1'b1;
          pc_sel       = PC_INC1;
          state_nxt    = S_ADDR;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ADDR;
      ir         <= '0;
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_operand <= '0;
      im_halt    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= im_instruction;
      if (dispatch_set) begin
        ex_valid   <= 1'b1;
        ex_opcode  <= ir_opcode;
        ex_operand <= ir_operand;
      end else if (dispatch_clr) begin
        ex_valid <= 1'b0;
      end
      if (halt_set) begin
        halted  <= 1'b1;
        im_halt <= 1'b1;
      end
    end
  end

endmodule
